// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Constants shared by the bit-serial arithmetic blocks.
//   DEFAULT_WIDTH : default operand/result width of the serial datapath
//   ST_IDLE/ST_RUN: FSM state encoding used by serial_subtractor_8
// ---------------------------------------------------------------------------
package arith_pkg;

    localparam int DEFAULT_WIDTH = 32'd8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage : arith_pkg

// File: rtl/serial_subtractor_8_full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
// One-bit combinational subtractor slice: computes a - b - bin.
// Ports:
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in from the less significant bit
//   d    : difference bit
//   bout : borrow out to the more significant bit
// ---------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a, or when a == b and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor_8.sv
// ---------------------------------------------------------------------------
// serial_subtractor_8
// Bit-serial unsigned subtractor: diff = (x - y) mod 2^WIDTH, borrow = (x < y).
// One bit is processed per clock, LSB first, through a single subtractor slice.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request, sampled only while idle
//   x, y   : minuend / subtrahend, captured on the accepting edge
//   diff   : result, held until the next completion
//   borrow : final borrow out
//   busy   : high while a subtraction is in progress
//   done   : one-cycle pulse when diff/borrow update
// ---------------------------------------------------------------------------
module serial_subtractor_8
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [0:0]       state_q,  state_d;
    logic [WIDTH-1:0] x_sh_q,   x_sh_d;
    logic [WIDTH-1:0] y_sh_q,   y_sh_d;
    logic [WIDTH-1:0] r_sh_q,   r_sh_d;
    logic             bin_q,    bin_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic             d_s;
    logic             bout_s;
    logic             cnt_last_s;
    logic [WIDTH-1:0] r_next_s;

    full_subtractor u_fs (
        .a    (x_sh_q[0]),
        .b    (y_sh_q[0]),
        .bin  (bin_q),
        .d    (d_s),
        .bout (bout_s)
    );

    assign cnt_last_s = (cnt_q == CNT_W'(WIDTH - 1));
    // New difference bit enters at the MSB so that after WIDTH shifts the
    // first (LSB) result bit has reached bit 0.
    assign r_next_s   = {d_s, r_sh_q[WIDTH-1:1]};

    // Next-state logic for the FSM, shift registers, counter and outputs.
    always_comb begin
        state_d  = state_q;
        x_sh_d   = x_sh_q;
        y_sh_d   = y_sh_q;
        r_sh_d   = r_sh_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_sh_d  = x;
                    y_sh_d  = y;
                    r_sh_d  = {WIDTH{1'b0}};
                    bin_d   = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                x_sh_d = {1'b0, x_sh_q[WIDTH-1:1]};
                y_sh_d = {1'b0, y_sh_q[WIDTH-1:1]};
                r_sh_d = r_next_s;
                bin_d  = bout_s;
                if (cnt_last_s) begin
                    cnt_d    = {CNT_W{1'b0}};
                    diff_d   = r_next_s;
                    borrow_d = bout_s;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            x_sh_q   <= {WIDTH{1'b0}};
            y_sh_q   <= {WIDTH{1'b0}};
            r_sh_q   <= {WIDTH{1'b0}};
            bin_q    <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            diff_q   <= {WIDTH{1'b0}};
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_sh_q   <= x_sh_d;
            y_sh_q   <= y_sh_d;
            r_sh_q   <= r_sh_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule : serial_subtractor_8

// File: tb/tb_serial_subtractor_8.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor_8
// Scoreboard bench: each issued subtraction pushes its expected result and
// completion cycle; a monitor pops and compares on every done pulse and checks
// that diff/borrow hold steady between completions.
// ---------------------------------------------------------------------------
module tb_serial_subtractor_8;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        int               cyc;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] x_v;
    logic [WIDTH-1:0] y_v;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             busy;
    logic             done;

    exp_t             sb_q[$];
    int               n_tests;
    int               n_fail;
    int               cyc;
    logic [WIDTH-1:0] hold_diff;
    logic             hold_borrow;

    serial_subtractor_8 #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .x      (x_v),
        .y      (y_v),
        .diff   (diff),
        .borrow (borrow),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to timestamp accepts and completions.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare on done pulses, otherwise outputs must hold.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_done: got done=1 expected no pending result (t=%0t)", $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("diff", 32'(diff), 32'(e.diff));
                    chk("borrow", 32'(borrow), 32'(e.borrow));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("busy_in_done", 32'(busy), 32'd0);
                    hold_diff   = e.diff;
                    hold_borrow = e.borrow;
                end
            end else begin
                chk("diff_hold", 32'(diff), 32'(hold_diff));
                chk("borrow_hold", 32'(borrow), 32'(hold_borrow));
            end
        end
    end

    task automatic wait_idle();
        int b = 0;
        while (busy === 1'b1 && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        if (busy !== 1'b0) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic drain();
        int b = 0;
        while (sb_q.size() > 0 && b < 200) begin
            @(posedge clk); #1;
            b++;
        end
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    // Issue one subtraction; the next rising edge accepts it.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        wait_idle();
        e.diff   = WIDTH'((int'(a) - int'(b) + 256) % 256);
        e.borrow = (a < b);
        e.cyc    = cyc + 1 + WIDTH;
        sb_q.push_back(e);
        start = 1'b1;
        x_v   = a;
        y_v   = b;
        @(posedge clk); #1;
        start = 1'b0;
        x_v   = WIDTH'($urandom);
        y_v   = WIDTH'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    initial begin
        int b;
        n_tests     = 0;
        n_fail      = 0;
        cyc         = 0;
        hold_diff   = '0;
        hold_borrow = 1'b0;
        rst_n       = 1'b0;
        start       = 1'b0;
        x_v         = '0;
        y_v         = '0;

        // Reset state.
        #1;
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases including wrap-around.
        do_op(8'h5A, 8'h23);
        do_op(8'h00, 8'h01);
        do_op(8'h80, 8'h80);
        do_op(8'hFF, 8'h00);
        drain();

        // Start while busy must be ignored.
        do_op(8'h10, 8'h05);
        repeat (2) begin @(posedge clk); #1; end
        start = 1'b1;
        x_v   = 8'hAA;
        y_v   = 8'h55;
        @(posedge clk); #1;
        start = 1'b0;
        drain();
        repeat (12) begin @(posedge clk); #1; end

        // Back-to-back: second start issued during the done cycle.
        do_op(8'h40, 8'h01);
        b = 0;
        while (done !== 1'b1 && b < 50) begin @(posedge clk); #1; b++; end
        chk("b2b_done_seen", 32'(done), 32'd1);
        do_op(8'h01, 8'h02);
        drain();

        // Asynchronous reset mid-run aborts the operation.
        do_op(8'h33, 8'h11);
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_borrow", 32'(borrow), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        sb_q.delete();
        hold_diff   = '0;
        hold_borrow = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("abort_done_held", 32'(done), 32'd0);
        #2 rst_n = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        do_op(8'h09, 8'h03);
        drain();

        // Randomized sweep against the arithmetic reference.
        for (int i = 0; i < 1000; i++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 12)) begin @(posedge clk); #1; end
            end
        end
        drain();
        repeat (3) begin @(posedge clk); #1; end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_subtractor_8
